// File: rtl/ldpc_pkg.sv
// LDPC rate definitions shared by the encoder and the bit packer:
// rate indices, q lookup, frame sizing and the packer FSM states.
package ldpc_pkg;

    localparam int CTRL_W        = 5;
    localparam int FRAME_BYTES_W = 13;

    localparam logic [CTRL_W-1:0] RATE_1_4  = 5'd0;
    localparam logic [CTRL_W-1:0] RATE_1_3  = 5'd1;
    localparam logic [CTRL_W-1:0] RATE_2_5  = 5'd2;
    localparam logic [CTRL_W-1:0] RATE_1_2  = 5'd3;
    localparam logic [CTRL_W-1:0] RATE_3_5  = 5'd4;
    localparam logic [CTRL_W-1:0] RATE_2_3  = 5'd5;
    localparam logic [CTRL_W-1:0] RATE_3_4  = 5'd6;
    localparam logic [CTRL_W-1:0] RATE_4_5  = 5'd7;
    localparam logic [CTRL_W-1:0] RATE_5_6  = 5'd8;
    localparam logic [CTRL_W-1:0] RATE_8_9  = 5'd9;
    localparam logic [CTRL_W-1:0] RATE_9_10 = 5'd10;
    localparam logic [CTRL_W-1:0] CTRL_MAX  = RATE_9_10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] q_of(input logic [CTRL_W-1:0] c);
        case (c)
            RATE_1_4:  return 8'd135;
            RATE_1_3:  return 8'd120;
            RATE_2_5:  return 8'd108;
            RATE_1_2:  return 8'd90;
            RATE_3_5:  return 8'd72;
            RATE_2_3:  return 8'd60;
            RATE_3_4:  return 8'd45;
            RATE_4_5:  return 8'd36;
            RATE_5_6:  return 8'd30;
            RATE_8_9:  return 8'd20;
            default:   return 8'd18;
        endcase
    endfunction

    // Bytes per frame: 360*(q-1) bits is always a whole number of bytes.
    function automatic logic [FRAME_BYTES_W-1:0] frame_bytes(input logic [CTRL_W-1:0] c);
        return FRAME_BYTES_W'(45 * (int'(q_of(c)) - 1));
    endfunction

endpackage

// File: rtl/ldpc_out_reg.sv
// Single-entry valid/ready holding register for a packed byte and its frame flags.
module ldpc_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_start,
    input  logic       load_end,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_start_frame,
    output logic       out_end_frame
);

    logic       valid_reg;
    logic [7:0] data_reg;
    logic       start_reg;
    logic       end_reg;

    // A load only arrives when the slot is empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= 8'h00;
            start_reg <= 1'b0;
            end_reg   <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            start_reg <= load_start;
            end_reg   <= load_end;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
            start_reg <= 1'b0;
            end_reg   <= 1'b0;
        end
    end

    assign out_valid       = valid_reg;
    assign out_data        = data_reg;
    assign out_start_frame = start_reg;
    assign out_end_frame   = end_reg;

endmodule

// File: rtl/ldpc_bit_packer.sv
// Packs the serial LDPC encoder bit stream MSB-first into bytes, framed by the
// rate-dependent frame length, and releases the encoder once the frame drains.
module ldpc_bit_packer
    import ldpc_pkg::*;
#(
    parameter int FRAME_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              ctrl_load,
    input  logic              enc_bits,
    input  logic              enc_valid,
    output logic              enc_ready,
    output logic              enc_dec_complete,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_start_frame,
    output logic              out_end_frame,
    output logic              out_err
);

    state_t                   state_reg;
    state_t                   state_next;
    logic [CTRL_W-1:0]        ctrl_reg;
    logic [FRAME_CNT_W-1:0]   bit_cnt_reg;
    logic [6:0]               shift_reg;
    logic                     err_reg;

    logic [FRAME_BYTES_W+2:0] last_bit_full;
    logic [FRAME_CNT_W-1:0]   last_bit;
    logic [2:0]               bit_idx;
    logic                     ctrl_ok;
    logic                     arm;
    logic                     accept;
    logic                     byte_done;
    logic                     last_accept;

    // Last bit index of the frame is frame_bytes*8-1.
    assign last_bit_full = {frame_bytes(ctrl_reg) - FRAME_BYTES_W'(1), 3'b111};
    assign last_bit      = FRAME_CNT_W'(last_bit_full);
    assign bit_idx       = bit_cnt_reg[2:0];

    assign ctrl_ok     = (ctrl <= CTRL_MAX);
    assign arm         = (state_reg == IDLE) && ctrl_load && ctrl_ok;
    // The eighth bit of a byte may only enter when the output slot is free or draining.
    assign enc_ready   = (state_reg == RUN) && ((bit_idx != 3'd7) || !out_valid || out_ready);
    assign accept      = enc_valid && enc_ready;
    assign byte_done   = accept && (bit_idx == 3'd7);
    assign last_accept = accept && (bit_cnt_reg == last_bit);

    assign enc_dec_complete = (state_reg == DONE);
    assign out_err          = err_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (arm) state_next = RUN;
            RUN:     if (last_accept) state_next = FLUSH;
            FLUSH:   if (out_valid && out_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ctrl_reg    <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= (state_reg == IDLE) && ctrl_load && !ctrl_ok;
            if (arm) begin
                ctrl_reg    <= ctrl;
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
            end else if (accept) begin
                shift_reg   <= {shift_reg[5:0], enc_bits};
                bit_cnt_reg <= last_accept ? '0 : bit_cnt_reg + FRAME_CNT_W'(1);
            end
        end
    end

    ldpc_out_reg u_out_reg (
        .clk             (clk),
        .rst             (rst),
        .load            (byte_done),
        .load_data       ({shift_reg, enc_bits}),
        .load_start      (bit_cnt_reg == FRAME_CNT_W'(7)),
        .load_end        (last_accept),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_start_frame (out_start_frame),
        .out_end_frame   (out_end_frame)
    );

endmodule
